// File: rtl/fetch_unit_pkg.sv
// Shared widths, opcode constants and FSM state type for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int PC_WIDTH   = 8;
  localparam int DATA_WIDTH = 16;
  localparam int OP_WIDTH   = 4;
  localparam int DEPTH      = 4;

  localparam logic [OP_WIDTH-1:0] STOP_OP  = 4'hF;
  localparam logic [PC_WIDTH-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STOP_WAIT = 2'd1,
    ST_HALT      = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of {pc, instr} pairs feeding IF/ID. The head outputs keep
// showing the last delivered entry while the queue is empty.
module fetch_queue #(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic [PC_WIDTH-1:0]           push_pc,
  input  logic [DATA_WIDTH-1:0]         push_instr,
  input  logic                          pop,
  output logic                          valid,
  output logic [PC_WIDTH-1:0]           head_pc,
  output logic [DATA_WIDTH-1:0]         head_instr,
  output logic [$clog2(DEPTH):0]        count
);
  import fetch_unit_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PC_WIDTH-1:0]   last_pc;
  logic [DATA_WIDTH-1:0] last_instr;

  assign valid      = (count != '0);
  assign head_pc    = valid ? pc_mem[rd_ptr]    : last_pc;
  assign head_instr = valid ? instr_mem[rd_ptr] : last_instr;

  // Pointer and occupancy bookkeeping; a flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset because occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  // Remember the current head so the outputs hold steady once the queue drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc    <= '0;
      last_instr <= '0;
    end else if (valid) begin
      last_pc    <= pc_mem[rd_ptr];
      last_instr <= instr_mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited in-order
// memory reads, buffers returned words and stops fetching after a STOP opcode.
module fetch_unit #(
  parameter int                                  PC_WIDTH   = fetch_unit_pkg::PC_WIDTH,
  parameter int                                  DATA_WIDTH = fetch_unit_pkg::DATA_WIDTH,
  parameter int                                  DEPTH      = fetch_unit_pkg::DEPTH,
  parameter logic [PC_WIDTH-1:0]                 RESET_PC   = fetch_unit_pkg::RESET_PC,
  parameter logic [fetch_unit_pkg::OP_WIDTH-1:0] STOP_OP    = fetch_unit_pkg::STOP_OP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  input  logic                  id_ready_i,
  output logic                  imem_req_o,
  output logic [PC_WIDTH-1:0]   imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [PC_WIDTH-1:0]   pc_plus1_o,
  output logic                  halted_o
);
  import fetch_unit_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e          state;
  logic                  halted_q;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   rsp_pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         q_count;
  logic [CW-1:0]         out_next;
  logic [CW-1:0]         cnt_after;
  logic [CW:0]           inflight;
  logic                  q_valid;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  is_stop;

  // Queue slots already taken plus slots promised to requests still in flight.
  assign inflight  = {1'b0, q_count} + {1'b0, outstanding};
  assign issue     = (state == ST_RUN) && !redirect_i && !rst && (inflight < (CW+1)'(DEPTH));
  assign push      = imem_rvalid_i && !redirect_i && (drop_cnt == '0) && (state == ST_RUN);
  assign pop       = q_valid && id_ready_i && !redirect_i;
  assign is_stop   = (imem_rdata_i[DATA_WIDTH-1 -: OP_WIDTH] == STOP_OP);
  assign out_next  = outstanding + CW'(issue) - CW'(imem_rvalid_i);
  assign cnt_after = q_count + CW'(push) - CW'(pop);

  assign imem_req_o    = issue;
  assign imem_addr_o   = pc;
  assign instr_valid_o = q_valid;
  assign pc_plus1_o    = pc_o + PC_WIDTH'(1);
  assign halted_o      = halted_q;

  fetch_queue #(
    .PC_WIDTH   (PC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_i),
    .push       (push),
    .push_pc    (rsp_pc),
    .push_instr (imem_rdata_i),
    .pop        (pop),
    .valid      (q_valid),
    .head_pc    (pc_o),
    .head_instr (instr_o),
    .count      (q_count)
  );

  // PC, in-flight/drop accounting and the RUN/STOP_WAIT/HALT control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      state       <= ST_RUN;
      halted_q    <= 1'b0;
    end else if (redirect_i) begin
      pc          <= redirect_pc_i;
      rsp_pc      <= redirect_pc_i;
      outstanding <= out_next;
      drop_cnt    <= out_next;
      state       <= ST_RUN;
      halted_q    <= 1'b0;
    end else begin
      if (issue) pc <= pc + PC_WIDTH'(1);
      if (push)  rsp_pc <= rsp_pc + PC_WIDTH'(1);
      outstanding <= out_next;
      if (imem_rvalid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      case (state)
        ST_RUN: begin
          if (push && is_stop) state <= ST_STOP_WAIT;
        end
        ST_STOP_WAIT: begin
          if ((cnt_after == '0) && (out_next == '0)) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default instance on a variable-latency
// memory model plus a second instance starting at PC 0xFE for wrap-around.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        id_ready;
  logic        req_a;
  logic [7:0]  addr_a;
  logic        rvalid_a;
  logic [15:0] rdata_a;
  logic        valid_a;
  logic [15:0] instr_a;
  logic [7:0]  pc_a;
  logic [7:0]  pc1_a;
  logic        halted_a;

  logic        redirect_b = 1'b0;
  logic [7:0]  redirect_pc_b = 8'h00;
  logic        id_ready_b = 1'b1;
  logic        req_b;
  logic [7:0]  addr_b;
  logic        rvalid_b = 1'b0;
  logic [15:0] rdata_b = 16'h0;
  logic        valid_b;
  logic [15:0] instr_b;
  logic [7:0]  pc_b;
  logic [7:0]  pc1_b;
  logic        halted_b;

  fetch_unit dut_a (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_ready_i    (id_ready),
    .imem_req_o    (req_a),
    .imem_addr_o   (addr_a),
    .imem_rvalid_i (rvalid_a),
    .imem_rdata_i  (rdata_a),
    .instr_valid_o (valid_a),
    .instr_o       (instr_a),
    .pc_o          (pc_a),
    .pc_plus1_o    (pc1_a),
    .halted_o      (halted_a)
  );

  fetch_unit #(.RESET_PC(8'hFE)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_b),
    .redirect_pc_i (redirect_pc_b),
    .id_ready_i    (id_ready_b),
    .imem_req_o    (req_b),
    .imem_addr_o   (addr_b),
    .imem_rvalid_i (rvalid_b),
    .imem_rdata_i  (rdata_b),
    .instr_valid_o (valid_b),
    .instr_o       (instr_b),
    .pc_o          (pc_b),
    .pc_plus1_o    (pc1_b),
    .halted_o      (halted_b)
  );

  // Memory model for dut_a: in-order, latency set by 'lat'
  int         cyc = 0;
  int         lat = 1;
  int         req_total = 0;
  logic       stop_en = 1'b0;
  logic [7:0] addr_q[$];
  int         due_q[$];

  function automatic logic [15:0] memWord(input logic [7:0] a);
    if (stop_en && (a == 8'h05)) return 16'hF000;
    return 16'h1000 + {8'h00, a};
  endfunction

  // Capture requests and retire delivered responses at the clock edge
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      addr_q.delete();
      due_q.delete();
      req_total = 0;
    end else begin
      if (rvalid_a) begin
        void'(addr_q.pop_front());
        void'(due_q.pop_front());
      end
      if (req_a) begin
        addr_q.push_back(addr_a);
        due_q.push_back(cyc + lat);
        req_total++;
      end
    end
  end

  // Present the oldest response once its latency has elapsed
  always @(negedge clk) begin
    if ((addr_q.size() != 0) && (due_q[0] <= cyc + 1)) begin
      rvalid_a = 1'b1;
      rdata_a  = memWord(addr_q[0]);
    end else begin
      rvalid_a = 1'b0;
      rdata_a  = 16'h0;
    end
  end

  // One-cycle memory for dut_b
  logic       pend_b = 1'b0;
  logic [7:0] pend_b_addr = 8'h00;

  always @(posedge clk) begin
    pend_b      = req_b && !rst;
    pend_b_addr = addr_b;
  end

  always @(negedge clk) begin
    rvalid_b = pend_b;
    rdata_b  = 16'h1000 + {8'h00, pend_b_addr};
  end

  task automatic applyStimulus(input logic r, input logic rd, input logic [7:0] rpc, input logic rdy);
    @(negedge clk);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    id_ready    = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag, input logic [15:0] instr, input logic [7:0] pc);
    checkOutput({tag, "_valid"}, 32'(valid_a), 32'd1);
    checkOutput({tag, "_instr"}, 32'(instr_a), 32'(instr));
    checkOutput({tag, "_pc"},    32'(pc_a),    32'(pc));
  endtask

  task automatic checkReq(input string tag, input logic [7:0] addr);
    checkOutput({tag, "_req"},  32'(req_a),  32'd1);
    checkOutput({tag, "_addr"}, 32'(addr_a), 32'(addr));
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; id_ready = 1'b1;

    $display("[TB] reset state");
    applyStimulus(1, 0, 8'h00, 1);
    applyStimulus(1, 0, 8'h00, 1);
    checkOutput("rst_req",    32'(req_a),    32'd0);
    checkOutput("rst_valid",  32'(valid_a),  32'd0);
    checkOutput("rst_instr",  32'(instr_a),  32'd0);
    checkOutput("rst_pc",     32'(pc_a),     32'd0);
    checkOutput("rst_pc1",    32'(pc1_a),    32'd1);
    checkOutput("rst_halted", 32'(halted_a), 32'd0);
    checkOutput("rst_b_pc1",  32'(pc1_b),    32'd1);

    $display("[TB] streaming with 1-cycle memory, PC wrap on second instance");
    applyStimulus(0, 0, 8'h00, 1);
    checkReq("t1_c0", 8'h00);
    checkOutput("t1_c0_b_addr", 32'(addr_b), 32'hFE);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t1_c1_valid", 32'(valid_a), 32'd0);
    checkReq("t1_c1", 8'h01);
    checkOutput("t1_c1_b_addr", 32'(addr_b), 32'hFF);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t1_c2", 16'h1000, 8'h00);
    checkOutput("t1_c2_pc1", 32'(pc1_a), 32'h01);
    checkOutput("t1_c2_b_addr",  32'(addr_b),  32'h00);
    checkOutput("t1_c2_b_valid", 32'(valid_b), 32'd1);
    checkOutput("t1_c2_b_instr", 32'(instr_b), 32'h10FE);
    checkOutput("t1_c2_b_pc",    32'(pc_b),    32'hFE);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t1_c3", 16'h1001, 8'h01);
    checkOutput("t1_c3_b_pc",   32'(pc_b),   32'hFF);
    checkOutput("t1_c3_b_pc1",  32'(pc1_b),  32'h00);
    checkOutput("t1_c3_b_addr", 32'(addr_b), 32'h01);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t1_c4", 16'h1002, 8'h02);

    $display("[TB] stall with 3-cycle memory");
    lat = 3;
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h00, 0);
    checkReq("t2_c0", 8'h00);
    repeat (3) applyStimulus(0, 0, 8'h00, 0);
    checkReq("t2_c3", 8'h03);
    applyStimulus(0, 0, 8'h00, 0);
    checkOutput("t2_c4_req", 32'(req_a), 32'd0);
    repeat (5) applyStimulus(0, 0, 8'h00, 0);
    checkOutput("t2_c9_req",  32'(req_a), 32'd0);
    checkOutput("t2_c9_reqs", 32'(req_total), 32'd4);
    checkHead("t2_c9", 16'h1000, 8'h00);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t2_c10_req", 32'(req_a), 32'd0);
    checkHead("t2_c10", 16'h1000, 8'h00);
    applyStimulus(0, 0, 8'h00, 1);
    checkReq("t2_c11", 8'h04);
    checkHead("t2_c11", 16'h1001, 8'h01);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t2_c12", 16'h1002, 8'h02);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t2_c13", 16'h1003, 8'h03);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t2_c14_valid", 32'(valid_a), 32'd0);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t2_c15", 16'h1004, 8'h04);

    $display("[TB] redirect with requests in flight");
    applyStimulus(1, 0, 8'h00, 0);
    repeat (4) applyStimulus(0, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h40, 0);
    checkOutput("t3_c4_req", 32'(req_a), 32'd0);
    checkHead("t3_c4", 16'h1000, 8'h00);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t3_c5_valid", 32'(valid_a), 32'd0);
    checkReq("t3_c5", 8'h40);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t3_c6_valid", 32'(valid_a), 32'd0);
    checkReq("t3_c6", 8'h41);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t3_c7_valid", 32'(valid_a), 32'd0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t3_c8_valid", 32'(valid_a), 32'd0);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t3_c9", 16'h1040, 8'h40);
    checkOutput("t3_c9_pc1", 32'(pc1_a), 32'h41);

    $display("[TB] STOP handling and restart");
    lat = 2;
    stop_en = 1'b1;
    applyStimulus(1, 0, 8'h00, 1);
    repeat (8) applyStimulus(0, 0, 8'h00, 1);
    checkReq("t5_c7", 8'h07);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t5_c8", 16'hF000, 8'h05);
    checkOutput("t5_c8_req",    32'(req_a),    32'd0);
    checkOutput("t5_c8_halted", 32'(halted_a), 32'd0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t5_c9_valid",  32'(valid_a),  32'd0);
    checkOutput("t5_c9_halted", 32'(halted_a), 32'd0);
    checkOutput("t5_c9_req",    32'(req_a),    32'd0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t5_c10_valid",  32'(valid_a),  32'd0);
    checkOutput("t5_c10_halted", 32'(halted_a), 32'd1);
    checkOutput("t5_c10_req",    32'(req_a),    32'd0);
    stop_en = 1'b0;
    applyStimulus(0, 1, 8'h10, 1);
    checkOutput("t5_c11_req", 32'(req_a), 32'd0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("t5_c12_halted", 32'(halted_a), 32'd0);
    checkReq("t5_c12", 8'h10);
    repeat (2) applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 0);
    checkHead("t5_c15", 16'h1010, 8'h10);

    $display("[TB] reset with a full queue");
    repeat (4) applyStimulus(0, 0, 8'h00, 0);
    checkHead("t6_c19", 16'h1010, 8'h10);
    checkOutput("t6_c19_req", 32'(req_a), 32'd0);
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("t6_c21_valid", 32'(valid_a), 32'd0);
    checkOutput("t6_c21_req",   32'(req_a),   32'd0);
    checkOutput("t6_c21_instr", 32'(instr_a), 32'd0);
    checkOutput("t6_c21_pc",    32'(pc_a),    32'd0);
    applyStimulus(0, 0, 8'h00, 1);
    checkReq("t6_c22", 8'h00);
    repeat (2) applyStimulus(0, 0, 8'h00, 1);
    applyStimulus(0, 0, 8'h00, 1);
    checkHead("t6_c25", 16'h1000, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
